// File: rtl/axi4_lite_read_slave.sv
// axi4_lite_read_slave: AXI4-Lite read-only slave returning snapshots of a locally written register bank
module axi4_lite_read_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int RD_WAIT = 0,
    localparam int IDXW = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] AR_ADDR,
    input  logic                  AR_VALID,
    output logic                  AR_READY,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  R_VALID,
    input  logic                  R_READY,
    output logic [1:0]            R_RESP,
    input  logic                  reg_wr_en,
    input  logic [IDXW-1:0]       reg_wr_idx,
    input  logic [DATA_WIDTH-1:0] reg_wr_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] WAIT_INIT = RD_WAIT > 0 ? 4'(RD_WAIT - 1) : 4'd0;
    state_t state, next_state;
    logic [3:0] cnt, cnt_n;
    logic [DATA_WIDTH-1:0] bank [NUM_REGS];
    logic [DATA_WIDTH-1:0] pend_data, pend_data_n;
    logic pend_err, pend_err_n;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDXW-1:0] idx;
    logic hit, accept;
    // Response is resolved at acceptance and parked in pend_* so R_DATA stays a snapshot.
    always_comb begin
        offset = AR_ADDR - BASE_ADDR;
        idx = offset[IDXW+1:2];
        hit = AR_ADDR >= BASE_ADDR && offset[1:0] == 2'b00 && offset[ADDR_WIDTH-1:IDXW+2] == '0;
        accept = state == IDLE && AR_READY && AR_VALID;
        next_state = state;
        cnt_n = cnt;
        pend_data_n = pend_data;
        pend_err_n = pend_err;
        if (accept) begin
            next_state = RD_WAIT > 0 ? WAIT : RESP;
            cnt_n = WAIT_INIT;
            pend_data_n = hit ? bank[idx] : '0;
            pend_err_n = !hit;
        end else if (state == WAIT) begin
            next_state = cnt == 4'd0 ? RESP : WAIT;
            cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        end else if (state == RESP && R_READY) begin
            next_state = IDLE;
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            pend_data <= '0;
            pend_err <= 1'b0;
            AR_READY <= 1'b0;
            R_VALID <= 1'b0;
            R_DATA <= '0;
            R_RESP <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else begin
            state <= next_state;
            cnt <= cnt_n;
            pend_data <= pend_data_n;
            pend_err <= pend_err_n;
            AR_READY <= next_state == IDLE;
            R_VALID <= next_state == RESP;
            R_DATA <= next_state == RESP ? pend_data_n : '0;
            R_RESP <= next_state == RESP && pend_err_n ? 2'b10 : 2'b00;
            if (reg_wr_en) bank[reg_wr_idx] <= reg_wr_data;
        end
    end
endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// tb_axi4_lite_read_slave: directed checks of two slave configurations against a transaction-level model
module tb_axi4_lite_read_slave;
    localparam logic [31:0] BASE [2] = '{32'h0, 32'h1000};
    localparam int WT [2] = '{0, 3};
    logic clk = 0;
    logic resetn = 0;
    logic [31:0] ar_addr [2];
    logic ar_valid [2];
    logic ar_ready [2];
    logic [31:0] r_data [2];
    logic r_valid [2];
    logic r_ready [2];
    logic [1:0] r_resp [2];
    logic reg_wr_en [2];
    logic [3:0] reg_wr_idx [2];
    logic [31:0] reg_wr_data [2];
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    axi4_lite_read_slave dut0 (
        .clk(clk), .resetn(resetn),
        .AR_ADDR(ar_addr[0]), .AR_VALID(ar_valid[0]), .AR_READY(ar_ready[0]),
        .R_DATA(r_data[0]), .R_VALID(r_valid[0]), .R_READY(r_ready[0]), .R_RESP(r_resp[0]),
        .reg_wr_en(reg_wr_en[0]), .reg_wr_idx(reg_wr_idx[0]), .reg_wr_data(reg_wr_data[0])
    );
    axi4_lite_read_slave #(.BASE_ADDR(32'h1000), .RD_WAIT(3)) dut1 (
        .clk(clk), .resetn(resetn),
        .AR_ADDR(ar_addr[1]), .AR_VALID(ar_valid[1]), .AR_READY(ar_ready[1]),
        .R_DATA(r_data[1]), .R_VALID(r_valid[1]), .R_READY(r_ready[1]), .R_RESP(r_resp[1]),
        .reg_wr_en(reg_wr_en[1]), .reg_wr_idx(reg_wr_idx[1]), .reg_wr_data(reg_wr_data[1])
    );
    // Transaction-level model: one pending read with a countdown until its data becomes visible.
    logic [31:0] m_bank [2][16];
    bit m_busy [2];
    int m_left [2];
    bit m_rdy [2];
    logic [31:0] m_data [2];
    logic [1:0] m_resp [2];
    logic [31:0] off;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] = 0; m_left[d] = 0; m_rdy[d] = 0; m_data[d] = 0; m_resp[d] = 0;
                for (int i = 0; i < 16; i++) m_bank[d][i] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_busy[d]) begin
                    if (m_left[d] > 0) m_left[d]--;
                    else if (r_ready[d]) m_busy[d] = 0;
                end else if (m_rdy[d] && ar_valid[d]) begin
                    off = ar_addr[d] - BASE[d];
                    if (ar_addr[d] >= BASE[d] && off % 4 == 0 && off / 4 < 16) begin
                        m_data[d] = m_bank[d][off / 4]; m_resp[d] = 2'b00;
                    end else begin
                        m_data[d] = 0; m_resp[d] = 2'b10;
                    end
                    m_busy[d] = 1;
                    m_left[d] = WT[d];
                end
                if (reg_wr_en[d]) m_bank[d][reg_wr_idx[d]] = reg_wr_data[d];
                m_rdy[d] = !m_busy[d];
            end
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit v;
            v = m_busy[d] && m_left[d] == 0;
            chk($sformatf("model_d%0d_ar_ready", d), 32'(ar_ready[d]), 32'(m_rdy[d]));
            chk($sformatf("model_d%0d_r_valid", d), 32'(r_valid[d]), 32'(v));
            chk($sformatf("model_d%0d_r_data", d), r_data[d], v ? m_data[d] : 32'h0);
            chk($sformatf("model_d%0d_r_resp", d), 32'(r_resp[d]), v ? 32'(m_resp[d]) : 32'h0);
        end
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic wr(input int d, input logic [3:0] idx, input logic [31:0] data);
        reg_wr_en[d] = 1; reg_wr_idx[d] = idx; reg_wr_data[d] = data;
        tick();
        reg_wr_en[d] = 0;
    endtask
    task automatic do_read(input int d, input logic [31:0] addr, input int hold, input bit w,
                           input logic [3:0] widx, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp, input int exp_lat);
        int n = 0;
        int lat = 1;
        while (!ar_ready[d] && n < 20) begin tick(); n++; end
        chk("ar_ready_before_read", 32'(ar_ready[d]), 1);
        ar_addr[d] = addr; ar_valid[d] = 1;
        reg_wr_en[d] = w; reg_wr_idx[d] = widx; reg_wr_data[d] = wdata;
        tick();
        ar_valid[d] = 0; reg_wr_en[d] = 0;
        while (!r_valid[d] && lat < 20) begin tick(); lat++; end
        chk("r_valid_seen", 32'(r_valid[d]), 1);
        chk("latency", lat, exp_lat);
        chk("r_data", r_data[d], exp_data);
        chk("r_resp", 32'(r_resp[d]), 32'(exp_resp));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_r_valid", 32'(r_valid[d]), 1);
            chk("hold_r_data", r_data[d], exp_data);
            chk("hold_r_resp", 32'(r_resp[d]), 32'(exp_resp));
            chk("hold_ar_ready", 32'(ar_ready[d]), 0);
        end
        r_ready[d] = 1;
        tick();
        r_ready[d] = 0;
        chk("done_r_valid", 32'(r_valid[d]), 0);
        chk("done_ar_ready", 32'(ar_ready[d]), 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int d = 0; d < 2; d++) begin
            ar_addr[d] = 0; ar_valid[d] = 0; r_ready[d] = 0;
            reg_wr_en[d] = 0; reg_wr_idx[d] = 0; reg_wr_data[d] = 0;
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_ar_ready", 32'(ar_ready[d]), 0);
            chk("reset_r_valid", 32'(r_valid[d]), 0);
            chk("reset_r_data", r_data[d], 0);
            chk("reset_r_resp", 32'(r_resp[d]), 0);
        end
        resetn = 1;
        #1 chk("ar_ready_before_first_edge", 32'(ar_ready[0]), 0);
        tick();
        chk("ar_ready_after_first_edge", 32'(ar_ready[0]), 1);
        wr(0, 4'd3, 32'hDEADBEEF);
        do_read(0, 32'h0C, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 1);
        do_read(0, 32'h0C, 5, 0, 0, 0, 32'hDEADBEEF, 2'b00, 1);
        do_read(0, 32'h40, 0, 0, 0, 0, 32'h0, 2'b10, 1);
        do_read(0, 32'h06, 0, 0, 0, 0, 32'h0, 2'b10, 1);
        wr(0, 4'd15, 32'hF00D000F);
        do_read(0, 32'h3C, 0, 0, 0, 0, 32'hF00D000F, 2'b00, 1);
        wr(1, 4'd1, 32'hCAFE0001);
        do_read(1, 32'h1004, 2, 0, 0, 0, 32'hCAFE0001, 2'b00, 4);
        do_read(1, 32'h0FFC, 0, 0, 0, 0, 32'h0, 2'b10, 4);
        do_read(1, 32'h1040, 0, 0, 0, 0, 32'h0, 2'b10, 4);
        wr(0, 4'd2, 32'h11);
        do_read(0, 32'h08, 1, 1, 4'd2, 32'h22, 32'h11, 2'b00, 1);
        do_read(0, 32'h08, 0, 0, 0, 0, 32'h22, 2'b00, 1);
        // Abort one read in RESP and one in WAIT with a mid-cycle reset.
        ar_addr[0] = 32'h0C; ar_valid[0] = 1;
        ar_addr[1] = 32'h1004; ar_valid[1] = 1;
        tick();
        ar_valid[0] = 0; ar_valid[1] = 0;
        tick();
        chk("pre_reset_r_valid", 32'(r_valid[0]), 1);
        resetn = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("abort_r_valid", 32'(r_valid[d]), 0);
            chk("abort_r_data", r_data[d], 0);
            chk("abort_ar_ready", 32'(ar_ready[d]), 0);
        end
        tick();
        resetn = 1;
        repeat (8) begin
            tick();
            chk("no_spurious_d0", 32'(r_valid[0]), 0);
            chk("no_spurious_d1", 32'(r_valid[1]), 0);
        end
        do_read(0, 32'h0C, 0, 0, 0, 0, 32'h0, 2'b00, 1);
        do_read(1, 32'h1004, 0, 0, 0, 0, 32'h0, 2'b00, 4);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
